mp3dec_seq_ctrl: RTL and testbench



---
 rtl/mp3dec_pkg.sv | 14 +
 rtl/mp3dec_stall_wdt.sv | 39 +++
 rtl/mp3dec_seq_ctrl.sv | 90 +++++++++
 tb/tb_mp3dec_seq_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mp3dec_pkg.sv
// mp3dec_pkg: shared state encoding and default sequencing parameters
package mp3dec_pkg;
  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_RST_ASSERT  = 3'd1,
    ST_RST_RELEASE = 3'd2,
    ST_PREFILL     = 3'd3,
    ST_RUN         = 3'd4,
    ST_DRAIN       = 3'd5
  } state_e;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_PREFILL_LVL  = 64;
  localparam int DEF_STALL_CYCLES = 4096;
endpackage

// File: rtl/mp3dec_stall_wdt.sv
// mp3dec_stall_wdt: output-FIFO progress watchdog with one-shot stall pulse
module mp3dec_stall_wdt #(
  parameter int LVL_W        = 10,
  parameter int CNT_W        = 16,
  parameter int STALL_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [LVL_W-1:0] ofifo_lvl_i,
  input  logic [LVL_W-1:0] ififo_lvl_i,
  output logic             stall_o
);
  localparam logic [CNT_W-1:0] MAX = CNT_W'(STALL_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LVL_W-1:0] prev_q;
  logic             armed_q, armed_d, stall_q, stall_d, chg;
  always_comb begin
    chg     = ofifo_lvl_i != prev_q;
    cnt_d   = (!en_i || chg) ? '0 : (cnt_q == MAX) ? MAX : cnt_q + CNT_W'(1);
    stall_d = en_i && armed_q && cnt_d == MAX && ififo_lvl_i != '0;
    // re-arm only on level movement, so a frozen level fires at most once
    armed_d = (!en_i || chg) ? 1'b1 : stall_d ? 1'b0 : armed_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      prev_q  <= '0;
      armed_q <= 1'b1;
      stall_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      prev_q  <= ofifo_lvl_i;
      armed_q <= armed_d;
      stall_q <= stall_d;
    end
  end
  assign stall_o = stall_q;
endmodule

// File: rtl/mp3dec_seq_ctrl.sv
// mp3dec_seq_ctrl: run sequencer ordering FIFO reset, decoder reset and enable
module mp3dec_seq_ctrl
  import mp3dec_pkg::*;
#(
  parameter int LVL_W        = 10,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int PREFILL_LVL  = DEF_PREFILL_LVL,
  parameter int STALL_CYCLES = DEF_STALL_CYCLES,
  parameter int CNT_W        = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             cmd_start,
  input  logic             cmd_abort,
  input  logic             eos,
  input  logic [LVL_W-1:0] ififo_rd_dcnt,
  input  logic [LVL_W-1:0] ofifo_wr_dcnt,
  input  logic             ififo_wrrst_busy,
  input  logic             ofifo_rdrst_busy,
  output logic             fifo_rst,
  output logic             dec_rst_n,
  output logic             dec_en,
  output logic [2:0]       state,
  output logic             done,
  output logic             stall
);
  localparam logic [31:0] PRE = PREFILL_LVL;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_rst_q, dec_rst_n_q, dec_en_q, done_q, done_d, pre_ok;
  // 32-bit compare so a threshold beyond the level range can only start on eos
  assign pre_ok = eos || 32'(ififo_rd_dcnt) >= PRE;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: if (cmd_start) begin
        state_d = ST_RST_ASSERT;
        cnt_d   = '0;
      end
      ST_RST_ASSERT: if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_RST_RELEASE;
        else cnt_d = cnt_q + CNT_W'(1);
      ST_RST_RELEASE: if (!ififo_wrrst_busy && !ofifo_rdrst_busy) state_d = ST_PREFILL;
      ST_PREFILL: if (pre_ok) state_d = ST_RUN;
      ST_RUN: if (eos && ififo_rd_dcnt == '0) state_d = ST_DRAIN;
      ST_DRAIN: if (ofifo_wr_dcnt == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (cmd_abort) begin
      state_d = ST_IDLE;
      done_d  = 1'b0;
    end
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fifo_rst_q  <= 1'b1;
      dec_rst_n_q <= 1'b0;
      dec_en_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fifo_rst_q  <= state_d inside {ST_IDLE, ST_RST_ASSERT};
      dec_rst_n_q <= state_d inside {ST_PREFILL, ST_RUN, ST_DRAIN};
      dec_en_q    <= state_d inside {ST_RUN, ST_DRAIN};
      done_q      <= done_d;
    end
  end
  mp3dec_stall_wdt #(
    .LVL_W(LVL_W), .CNT_W(CNT_W), .STALL_CYCLES(STALL_CYCLES)
  ) u_wdt (
    .clk        (HCLK),
    .rst        (HRESET),
    .en_i       (state_q == ST_RUN),
    .ofifo_lvl_i(ofifo_wr_dcnt),
    .ififo_lvl_i(ififo_rd_dcnt),
    .stall_o    (stall)
  );
  assign fifo_rst  = fifo_rst_q;
  assign dec_rst_n = dec_rst_n_q;
  assign dec_en    = dec_en_q;
  assign state     = state_q;
  assign done      = done_q;
endmodule

// File: tb/tb_mp3dec_seq_ctrl.sv
// tb_mp3dec_seq_ctrl: directed checks of sequencing, watchdog and abort paths
module tb_mp3dec_seq_ctrl;
  logic       HCLK = 0, HRESET = 1, cmd_start = 0, cmd_abort = 0, eos = 0;
  logic [9:0] ififo_rd_dcnt = 0, ofifo_wr_dcnt = 0;
  logic       ififo_wrrst_busy = 0, ofifo_rdrst_busy = 0;
  logic       fifo_rst, dec_rst_n, dec_en, done, stall;
  logic [2:0] state;
  int         total = 0, bad = 0;

  mp3dec_seq_ctrl #(.LVL_W(10), .RST_CYCLES(16), .PREFILL_LVL(64), .STALL_CYCLES(8), .CNT_W(16)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .cmd_start(cmd_start), .cmd_abort(cmd_abort), .eos(eos),
    .ififo_rd_dcnt(ififo_rd_dcnt), .ofifo_wr_dcnt(ofifo_wr_dcnt),
    .ififo_wrrst_busy(ififo_wrrst_busy), .ofifo_rdrst_busy(ofifo_rdrst_busy),
    .fifo_rst(fifo_rst), .dec_rst_n(dec_rst_n), .dec_en(dec_en), .state(state),
    .done(done), .stall(stall)
  );

  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [2:0] st, input logic fr, input logic rn,
                          input logic en, input logic dn);
    chk({tag, ".state"}, 32'(state), 32'(st));
    chk({tag, ".fifo_rst"}, 32'(fifo_rst), 32'(fr));
    chk({tag, ".dec_rst_n"}, 32'(dec_rst_n), 32'(rn));
    chk({tag, ".dec_en"}, 32'(dec_en), 32'(en));
    chk({tag, ".done"}, 32'(done), 32'(dn));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st);
    for (int i = 0; i < 60 && state != st; i++) step();
    chk({tag, ".reach"}, 32'(state), 32'(st));
  endtask

  task automatic stall_window(input string tag);
    int first = -1, pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (stall) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk({tag, ".first"}, 32'(first), 32'd7);
    chk({tag, ".pulses"}, 32'(pulses), 32'd1);
  endtask

  initial begin
    int n;
    step();
    step();
    chk_outs("reset", 3'd0, 1, 0, 0, 0);
    chk("reset.stall", 32'(stall), 32'd0);
    HRESET = 0;
    step();
    chk_outs("idle", 3'd0, 1, 0, 0, 0);

    // full start sequence
    ififo_wrrst_busy = 1;
    cmd_start = 1;
    step();
    cmd_start = 0;
    chk_outs("rst_assert", 3'd1, 1, 0, 0, 0);
    n = 1;
    for (int i = 0; i < 40 && state == 3'd1; i++) begin
      step();
      if (state == 3'd1) n++;
    end
    chk("rst_len", 32'(n), 32'd16);
    chk_outs("release", 3'd2, 0, 0, 0, 0);
    step();
    chk("release_hold", 32'(state), 32'd2);
    ififo_wrrst_busy = 0;
    step();
    chk_outs("prefill", 3'd3, 0, 1, 0, 0);
    ififo_rd_dcnt = 63;
    step();
    step();
    chk_outs("prefill63", 3'd3, 0, 1, 0, 0);
    ififo_rd_dcnt = 64;
    step();
    chk_outs("run", 3'd4, 0, 1, 1, 0);
    cmd_start = 1;
    step();
    cmd_start = 0;
    chk_outs("run_start_ign", 3'd4, 0, 1, 1, 0);

    // watchdog: two separate frozen windows
    ofifo_wr_dcnt = 100;
    ififo_rd_dcnt = 50;
    step();
    stall_window("stall1");
    ofifo_wr_dcnt = 101;
    step();
    chk("stall_chg", 32'(stall), 32'd0);
    stall_window("stall2");
    chk("stall_state", 32'(state), 32'd4);

    // drain and completion
    eos = 1;
    ififo_rd_dcnt = 0;
    step();
    chk_outs("drain", 3'd5, 0, 1, 1, 0);
    eos = 0;
    step();
    chk_outs("drain_eos_low", 3'd5, 0, 1, 1, 0);
    ofifo_wr_dcnt = 5;
    step();
    chk_outs("drain5", 3'd5, 0, 1, 1, 0);
    ofifo_wr_dcnt = 0;
    step();
    chk_outs("done", 3'd0, 1, 0, 0, 1);
    step();
    chk_outs("done_pulse", 3'd0, 1, 0, 0, 0);

    // eos start from a low level, then abort in RUN
    cmd_start = 1;
    step();
    cmd_start = 0;
    wait_state("p2", 3'd3);
    ififo_rd_dcnt = 10;
    step();
    chk("p2_hold", 32'(state), 32'd3);
    eos = 1;
    step();
    chk_outs("eos_run", 3'd4, 0, 1, 1, 0);
    eos = 0;
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    chk_outs("abort_run", 3'd0, 1, 0, 0, 0);

    // abort in RST_ASSERT
    cmd_start = 1;
    step();
    cmd_start = 0;
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    chk_outs("abort_rsta", 3'd0, 1, 0, 0, 0);

    // abort in RST_RELEASE
    ofifo_rdrst_busy = 1;
    cmd_start = 1;
    step();
    cmd_start = 0;
    wait_state("rr", 3'd2);
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    chk_outs("abort_rrel", 3'd0, 1, 0, 0, 0);
    ofifo_rdrst_busy = 0;

    // abort in PREFILL
    ififo_rd_dcnt = 0;
    cmd_start = 1;
    step();
    cmd_start = 0;
    wait_state("pf", 3'd3);
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    chk_outs("abort_pref", 3'd0, 1, 0, 0, 0);

    // abort coincident with DRAIN exit
    ofifo_wr_dcnt = 3;
    eos = 1;
    cmd_start = 1;
    step();
    cmd_start = 0;
    wait_state("dr", 3'd5);
    ofifo_wr_dcnt = 0;
    cmd_abort = 1;
    step();
    cmd_abort = 0;
    eos = 0;
    chk_outs("abort_drain", 3'd0, 1, 0, 0, 0);

    // start and abort together in IDLE
    cmd_start = 1;
    cmd_abort = 1;
    step();
    cmd_start = 0;
    cmd_abort = 0;
    chk_outs("start_abort", 3'd0, 1, 0, 0, 0);
    step();
    chk("start_abort2", 32'(state), 32'd0);

    // reset mid-RUN, then a normal run
    cmd_start = 1;
    step();
    cmd_start = 0;
    wait_state("r3", 3'd3);
    ififo_rd_dcnt = 64;
    step();
    chk("r3_run", 32'(state), 32'd4);
    HRESET = 1;
    step();
    HRESET = 0;
    chk_outs("midreset", 3'd0, 1, 0, 0, 0);
    chk("midreset.stall", 32'(stall), 32'd0);
    cmd_start = 1;
    step();
    cmd_start = 0;
    chk("r4_rsta", 32'(state), 32'd1);
    wait_state("r4", 3'd3);
    step();
    chk_outs("r4_run", 3'd4, 0, 1, 1, 0);
    eos = 1;
    ififo_rd_dcnt = 0;
    step();
    chk("r4_drain", 32'(state), 32'd5);
    step();
    chk_outs("r4_done", 3'd0, 1, 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
